// File: rtl/sensor_scan_adc.sv
// Round-robin three-channel scanner for an MCP3008-style 10-bit SPI ADC.
// Commits each channel's code to its sensor register, flags rail-stuck codes and pulses sen_valid per scan.
module sensor_scan_adc #(
  parameter int CH_1     = 0,
  parameter int CH_2     = 1,
  parameter int CH_3     = 2,
  parameter int SCAN_GAP = 16
) (
  input  logic        clk_16ms,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  output logic [15:0] sen_1,
  output logic [15:0] sen_2,
  output logic [15:0] sen_3,
  output logic [2:0]  sen_fault,
  output logic        sen_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_END   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [2:0]  CH1_IDX = 3'(CH_1);
  localparam logic [2:0]  CH2_IDX = 3'(CH_2);
  localparam logic [2:0]  CH3_IDX = 3'(CH_3);
  localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP - 1);

  state_t      state_r, state_s;
  logic [4:0]  k_r, k_s;
  logic [1:0]  ptr_r, ptr_s;
  logic        end_r, end_s;
  logic [15:0] gap_r, gap_s;
  logic [9:0]  shreg_r;
  logic [2:0]  ch_s;
  logic        cs_n_s, sclk_s, mosi_s, valid_s, busy_s;

  // A code pinned at either rail indicates an open or shorted sensor.
  function automatic logic rail_fault(input logic [9:0] code);
    return (code == 10'h000) || (code == 10'h3FF);
  endfunction

  // Next-state, counters and next values of the registered SPI/status outputs.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    ptr_s   = ptr_r;
    end_s   = end_r;
    gap_s   = gap_r;
    case (state_r)
      S_IDLE: begin
        if (enable) begin
          state_s = S_SETUP;
          ptr_s   = 2'd1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        state_s = S_SHIFT;
        k_s     = 5'd0;
      end
      S_SHIFT: begin
        if (k_r == 5'd31) begin
          state_s = S_END;
          end_s   = 1'b0;
        end else begin
          k_s = k_r + 5'd1;
        end
      end
      S_END: begin
        if (!end_r) begin
          end_s = 1'b1;
        end else if (ptr_r != 2'd3) begin
          ptr_s   = ptr_r + 2'd1;
          state_s = S_SETUP;
        end else begin
          state_s = S_GAP;
          gap_s   = 16'd0;
        end
      end
      S_GAP: begin
        if (gap_r == GAP_LAST) begin
          if (enable) begin
            state_s = S_SETUP;
            ptr_s   = 2'd1;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          gap_s = gap_r + 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    case (ptr_s)
      2'd1:    ch_s = CH1_IDX;
      2'd2:    ch_s = CH2_IDX;
      2'd3:    ch_s = CH3_IDX;
      default: ch_s = CH1_IDX;
    endcase

    cs_n_s  = !((state_s == S_SETUP) || (state_s == S_SHIFT));
    sclk_s  = (state_s == S_SHIFT) && k_s[0];
    valid_s = (state_s == S_GAP) && (state_r == S_END);
    busy_s  = (state_s != S_IDLE);

    // Command bits per period: start, single-ended, D2, D1, D0, then zeros.
    if (state_s == S_SETUP) begin
      mosi_s = 1'b1;
    end else if (state_s == S_SHIFT) begin
      case (k_s[4:1])
        4'd0:    mosi_s = 1'b1;
        4'd1:    mosi_s = 1'b1;
        4'd2:    mosi_s = ch_s[2];
        4'd3:    mosi_s = ch_s[1];
        4'd4:    mosi_s = ch_s[0];
        default: mosi_s = 1'b0;
      endcase
    end else begin
      mosi_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_16ms or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      k_r       <= 5'd0;
      ptr_r     <= 2'd1;
      end_r     <= 1'b0;
      gap_r     <= 16'd0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      adc_mosi  <= 1'b0;
      sen_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      ptr_r     <= ptr_s;
      end_r     <= end_s;
      gap_r     <= gap_s;
      adc_cs_n  <= cs_n_s;
      adc_sclk  <= sclk_s;
      adc_mosi  <= mosi_s;
      sen_valid <= valid_s;
      busy      <= busy_s;
    end
  end

  // MISO capture on rising SCLK for periods 7..16, then commit on entry to END.
  always_ff @(posedge clk_16ms or negedge rst) begin
    if (!rst) begin
      shreg_r   <= 10'd0;
      sen_1     <= 16'd0;
      sen_2     <= 16'd0;
      sen_3     <= 16'd0;
      sen_fault <= 3'b000;
    end else if (state_r == S_SHIFT) begin
      if (!k_r[0] && (k_r >= 5'd12)) begin
        shreg_r <= {shreg_r[8:0], adc_miso};
      end
      if (k_r == 5'd31) begin
        case (ptr_r)
          2'd1: begin
            sen_1        <= {6'b000000, shreg_r};
            sen_fault[0] <= rail_fault(shreg_r);
          end
          2'd2: begin
            sen_2        <= {6'b000000, shreg_r};
            sen_fault[1] <= rail_fault(shreg_r);
          end
          2'd3: begin
            sen_3        <= {6'b000000, shreg_r};
            sen_fault[2] <= rail_fault(shreg_r);
          end
          default: begin
            sen_1 <= sen_1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_scan_adc.sv
// Bench for sensor_scan_adc: a behavioural MCP3008 model decodes MOSI commands and
// serves per-channel codes; each test checks committed readings, flags and timing.
module tb_sensor_scan_adc;

  localparam int CH_1 = 0;
  localparam int CH_2 = 1;
  localparam int CH_3 = 2;
  localparam int GAP  = 16;
  localparam int GAP4 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        miso = 1'b0;
  logic        cs_n, sclk, mosi, sen_valid, busy;
  logic [15:0] sen_1, sen_2, sen_3;
  logic [2:0]  sen_fault;

  logic        enable4 = 1'b1;
  logic        miso4 = 1'b0;
  logic        cs_n4, sclk4, mosi4, sen_valid4, busy4;
  logic [15:0] s41, s42, s43;
  logic [2:0]  fault4;

  int compared = 0;
  int mismatched = 0;

  sensor_scan_adc #(.CH_1(CH_1), .CH_2(CH_2), .CH_3(CH_3), .SCAN_GAP(GAP)) dut (
    .clk_16ms(clk), .rst(rst), .enable(enable), .adc_miso(miso),
    .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_mosi(mosi),
    .sen_1(sen_1), .sen_2(sen_2), .sen_3(sen_3),
    .sen_fault(sen_fault), .sen_valid(sen_valid), .busy(busy));

  sensor_scan_adc #(.CH_1(CH_1), .CH_2(CH_2), .CH_3(CH_3), .SCAN_GAP(GAP4)) dut4 (
    .clk_16ms(clk), .rst(rst), .enable(enable4), .adc_miso(miso4),
    .adc_cs_n(cs_n4), .adc_sclk(sclk4), .adc_mosi(mosi4),
    .sen_1(s41), .sen_2(s42), .sen_3(s43),
    .sen_fault(fault4), .sen_valid(sen_valid4), .busy(busy4));

  always #5 clk = ~clk;

  // ADC model state
  logic [9:0] codes [0:7];
  logic [4:0] cmd_bits;
  logic [2:0] cur_ch;
  logic [4:0] cmd_q [$];
  int         gap_q [$];
  int         rise_q [$];
  int         period = 0;
  int         hi_run = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  int         bad_main = 0;
  int         bad4 = 0;

  always @(posedge clk) begin
    #1;
    if (cs_n && sclk) bad_main++;
    if (cs_n4 && sclk4) bad4++;
    if (!rst) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; period = 0; hi_run = 0; miso = 1'b0;
    end else begin
      if (!cs_n) begin
        if (prev_cs) begin
          period = 0;
          if (hi_run > 0) gap_q.push_back(hi_run);
          hi_run = 0;
        end
        if (!prev_sclk && sclk) begin
          period++;
          if (period <= 5) cmd_bits[5 - period] = mosi;
          if (period == 5) begin
            cur_ch = cmd_bits[2:0];
            cmd_q.push_back(cmd_bits);
          end
        end
        if (!sclk) begin
          if (period + 1 >= 7 && period + 1 <= 16) miso = codes[cur_ch][16 - (period + 1)];
          else miso = 1'b0;
        end
      end else begin
        if (!prev_cs) rise_q.push_back(period);
        hi_run++;
        miso = 1'b0;
      end
      prev_cs = cs_n;
      prev_sclk = sclk;
    end
  end

  function automatic logic [15:0] exp_sen(input int ch);
    return {6'b000000, codes[ch]};
  endfunction

  function automatic logic [2:0] exp_fault();
    logic [2:0] f;
    f[0] = (codes[CH_1] == 10'h000) || (codes[CH_1] == 10'h3FF);
    f[1] = (codes[CH_2] == 10'h000) || (codes[CH_2] == 10'h3FF);
    f[2] = (codes[CH_3] == 10'h000) || (codes[CH_3] == 10'h3FF);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (sen_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    compared++;
    if ({cs_n, sclk, mosi, sen_valid, busy} !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 10000", {cs_n, sclk, mosi, sen_valid, busy});
    end
    compared++;
    if ({sen_1, sen_2, sen_3, sen_fault} !== 51'd0) begin
      mismatched++;
      $display("FAIL reset_sen: got %h %h %h %b expected zeros", sen_1, sen_2, sen_3, sen_fault);
    end
  endtask

  task automatic test_scan();
    int n;
    bit ok;
    codes[0] = 10'h155; codes[1] = 10'h2AA; codes[2] = 10'h0C8;
    enable = 1'b1;
    rst = 1'b1;
    step();
    compared++;
    if ({cs_n, busy} !== 2'b01) begin
      mismatched++;
      $display("FAIL scan_setup: got cs_n/busy %b expected 01", {cs_n, busy});
    end
    wait_valid(400, n, ok);
    compared++;
    if (!ok || n != 105) begin
      mismatched++;
      $display("FAIL scan_latency: got %0d cycles (seen %0d) expected 105", n, ok);
    end
    compared++;
    if ({sen_1, sen_2, sen_3} !== {16'h0155, 16'h02AA, 16'h00C8} || sen_fault !== 3'b000) begin
      mismatched++;
      $display("FAIL scan_values: got %h %h %h %b expected 0155 02aa 00c8 000",
               sen_1, sen_2, sen_3, sen_fault);
    end
    step();
    compared++;
    if (sen_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL scan_pulse_width: got sen_valid %b expected 0", sen_valid);
    end
  endtask

  task automatic test_mosi();
    int n;
    bit ok;
    logic [4:0] exp_cmd [3];
    exp_cmd[0] = 5'b11000; exp_cmd[1] = 5'b11001; exp_cmd[2] = 5'b11010;
    wait_valid(400, n, ok);
    cmd_q.delete(); gap_q.delete(); rise_q.delete();
    wait_valid(400, n, ok);
    compared++;
    if (!ok || cmd_q.size() != 3 || gap_q.size() != 3 || rise_q.size() != 3) begin
      mismatched++;
      $display("FAIL mosi_frames: got %0d cmds %0d gaps %0d frames expected 3/3/3",
               cmd_q.size(), gap_q.size(), rise_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (cmd_q[i] !== exp_cmd[i] || rise_q[i] != 16) begin
          mismatched++;
          $display("FAIL mosi_cmd%0d: got %b with %0d sclk rises expected %b with 16",
                   i, cmd_q[i], rise_q[i], exp_cmd[i]);
        end
      end
      compared++;
      if (gap_q[0] != 2 + GAP || gap_q[1] != 2 || gap_q[2] != 2) begin
        mismatched++;
        $display("FAIL cs_high_runs: got %0d %0d %0d expected %0d 2 2",
                 gap_q[0], gap_q[1], gap_q[2], 2 + GAP);
      end
    end
  endtask

  task automatic test_fault();
    int n;
    bit ok;
    wait_valid(400, n, ok);
    codes[0] = 10'h3FF; codes[1] = 10'h000; codes[2] = 10'h200;
    wait_valid(400, n, ok);
    compared++;
    if (!ok || sen_fault !== 3'b011 || sen_1 !== 16'h03FF || sen_2 !== 16'h0000 || sen_3 !== 16'h0200) begin
      mismatched++;
      $display("FAIL fault_flags: got %b %h %h %h expected 011 03ff 0000 0200",
               sen_fault, sen_1, sen_2, sen_3);
    end
  endtask

  task automatic test_random();
    int n;
    bit ok;
    for (int s = 0; s < 4; s++) begin
      wait_valid(400, n, ok);
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 3) == 0) codes[c] = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'h000;
        else codes[c] = 10'($urandom_range(0, 1023));
      end
      wait_valid(400, n, ok);
      compared++;
      if (!ok || n != 105 + GAP || sen_1 !== exp_sen(CH_1) || sen_2 !== exp_sen(CH_2) ||
          sen_3 !== exp_sen(CH_3) || sen_fault !== exp_fault()) begin
        mismatched++;
        $display("FAIL random_scan%0d: got %h %h %h %b after %0d expected %h %h %h %b after %0d",
                 s, sen_1, sen_2, sen_3, sen_fault, n,
                 exp_sen(CH_1), exp_sen(CH_2), exp_sen(CH_3), exp_fault(), 105 + GAP);
      end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int nb;
    int pulses;
    bit ok;
    wait_valid(400, n, ok);
    repeat (62) step();
    compared++;
    if ({cs_n, sclk} !== 2'b00) begin
      mismatched++;
      $display("FAIL drop_point: got cs_n/sclk %b expected 00", {cs_n, sclk});
    end
    enable = 1'b0;
    wait_valid(200, n, ok);
    compared++;
    if (!ok || n != 59 || sen_1 !== exp_sen(CH_1) || sen_2 !== exp_sen(CH_2) || sen_3 !== exp_sen(CH_3)) begin
      mismatched++;
      $display("FAIL drop_complete: got valid after %0d (seen %0d) sen %h %h %h expected 59",
               n, ok, sen_1, sen_2, sen_3);
    end
    nb = 0;
    pulses = 0;
    while (busy && nb < 60) begin
      step();
      nb++;
      if (sen_valid) pulses++;
    end
    compared++;
    if (nb != GAP || pulses != 0) begin
      mismatched++;
      $display("FAIL drop_gap: got idle after %0d with %0d extra pulses expected %0d and 0", nb, pulses, GAP);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sen_valid || busy || !cs_n) pulses++;
    end
    compared++;
    if (pulses != 0 || sen_1 !== exp_sen(CH_1) || sen_2 !== exp_sen(CH_2) || sen_3 !== exp_sen(CH_3)) begin
      mismatched++;
      $display("FAIL idle_hold: got %0d active cycles sen %h %h %h expected 0 and %h %h %h",
               pulses, sen_1, sen_2, sen_3, exp_sen(CH_1), exp_sen(CH_2), exp_sen(CH_3));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    codes[0] = 10'h155; codes[1] = 10'h2AA; codes[2] = 10'h0C8;
    enable = 1'b1;
    wait_valid(400, n, ok);
    repeat (37) step();
    rst = 1'b0;
    #1;
    compared++;
    if ({cs_n, sclk, busy} !== 3'b100 || {sen_1, sen_2, sen_3} !== 48'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got cs/sclk/busy %b sen %h %h %h expected 100 and zeros",
               {cs_n, sclk, busy}, sen_1, sen_2, sen_3);
    end
    step();
    step();
    rst = 1'b1;
    step();
    compared++;
    if (cs_n !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_restart: got cs_n %b expected 0", cs_n);
    end
    wait_valid(400, n, ok);
    compared++;
    if (!ok || n != 105 || {sen_1, sen_2, sen_3} !== {16'h0155, 16'h02AA, 16'h00C8}) begin
      mismatched++;
      $display("FAIL reset_rescan: got %h %h %h after %0d expected 0155 02aa 00c8 after 105",
               sen_1, sen_2, sen_3, n);
    end
  endtask

  task automatic test_gap4();
    int n;
    bool_loop: for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!sen_valid4 && n < 400);
      if (p > 0) begin
        compared++;
        if (n != 105 + GAP4) begin
          mismatched++;
          $display("FAIL gap4_period%0d: got %0d expected %0d", p, n, 105 + GAP4);
        end
      end
    end
    compared++;
    if (bad_main != 0 || bad4 != 0) begin
      mismatched++;
      $display("FAIL sclk_idle: got %0d/%0d sclk-high cycles with cs_n high expected 0/0", bad_main, bad4);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) codes[i] = 10'h000;
    test_reset();
    test_scan();
    test_mosi();
    test_fault();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_gap4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
